// File: rtl/gameboard_pkg.sv
// Shared constants for the board scanner: grid geometry, tile colours and FSM encoding.
package gameboard_pkg;

  localparam int GRID_DIM  = 8;
  localparam int NUM_TILES = GRID_DIM * GRID_DIM;

  localparam logic [2:0] COLOR_MINE   = 3'b000;
  localparam logic [2:0] COLOR_STEP   = 3'b010;
  localparam logic [2:0] COLOR_FLAG   = 3'b100;
  localparam logic [2:0] COLOR_HIDDEN = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_SKIP = 3'd4,
    S_FIN  = 3'd5
  } state_e;

endpackage

// File: rtl/board_scanner_if.sv
// Scanner-to-tile-drawer link: draw request, tile coordinates/colour, completion pulse.
interface board_scanner_if;
  // tile_go pulses for one cycle with tile_x/tile_y/tile_color valid; those stay
  // stable until the drawer answers with a one-cycle tile_done pulse.
  logic       tile_go;
  logic       tile_done;
  logic [7:0] tile_x;
  logic [6:0] tile_y;
  logic [2:0] tile_color;

  modport master (output tile_go, output tile_x, output tile_y, output tile_color,
                  input  tile_done);
  modport slave  (input  tile_go, input  tile_x, input  tile_y, input  tile_color,
                  output tile_done);
endinterface

// File: rtl/tile_color_lut.sv
// Priority colour select for one tile from its mine/flag/step bits.
module tile_color_lut
  import gameboard_pkg::*;
(
  input  logic       mine_i,
  input  logic       flag_i,
  input  logic       step_i,
  output logic [2:0] color_o
);

  always_comb begin
    color_o = COLOR_HIDDEN;
    if (step_i)      color_o = mine_i ? COLOR_MINE : COLOR_STEP;
    else if (flag_i) color_o = COLOR_FLAG;
  end

endmodule

// File: rtl/board_scanner.sv
// Walks all 64 tiles of a snapshotted board and hands each one to the tile drawer.
// Optional BOARD_SCANNER_DIRTY_ONLY_EN skips tiles whose colour is unchanged since last drawn.
module board_scanner
  import gameboard_pkg::*;
#(
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 0,
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_TILES-1:0]   mine_map,
  input  logic [NUM_TILES-1:0]   flag_map,
  input  logic [NUM_TILES-1:0]   step_map,
  board_scanner_if.master        drw,
  output logic                   busy,
  output logic                   frame_done,
  output state_e                 dbg_state_o
);

  state_e               state_q;
  logic [5:0]           idx_q;
  logic [NUM_TILES-1:0] mine_q, flag_q, step_q;
  logic                 tile_go_q, frame_done_q;
  logic [7:0]           x_q;
  logic [6:0]           y_q;
  logic [2:0]           color_q;

  logic [5:0] nidx_d;
  logic       nm_d, nf_d, ns_d, nskip_d, adv_d, last_d;
  logic [2:0] ncolor_d;
  logic [7:0] nx_d;
  logic [6:0] ny_d;

  // The tile about to be issued: tile 0 straight from the live maps while snapshotting.
  always_comb begin
    nidx_d = (state_q == S_SNAP) ? 6'd0 : idx_q + 6'd1;
    if (state_q == S_SNAP) begin
      nm_d = mine_map[nidx_d];
      nf_d = flag_map[nidx_d];
      ns_d = step_map[nidx_d];
    end else begin
      nm_d = mine_q[nidx_d];
      nf_d = flag_q[nidx_d];
      ns_d = step_q[nidx_d];
    end
    nx_d   = 8'(X_ORIGIN + 32'(nidx_d[2:0]) * TILE_W);
    ny_d   = 7'(Y_ORIGIN + 32'(nidx_d[5:3]) * TILE_H);
    last_d = (idx_q == 6'(NUM_TILES - 1));
    adv_d  = (state_q == S_SNAP)
           | ((state_q == S_WAIT) & drw.tile_done & ~last_d)
`ifdef BOARD_SCANNER_DIRTY_ONLY_EN
           | ((state_q == S_SKIP) & ~last_d)
`endif
           ;
  end

  tile_color_lut u_lut (
    .mine_i  (nm_d),
    .flag_i  (nf_d),
    .step_i  (ns_d),
    .color_o (ncolor_d)
  );

`ifdef BOARD_SCANNER_DIRTY_ONLY_EN
  logic [2:0]           store_q [NUM_TILES];
  logic [NUM_TILES-1:0] valid_q;

  assign nskip_d = valid_q[nidx_d] && (store_q[nidx_d] == ncolor_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (state_q == S_WAIT && drw.tile_done) begin
      store_q[idx_q] <= color_q;
      valid_q[idx_q] <= 1'b1;
    end
  end
`else
  assign nskip_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mine_q       <= '0;
      flag_q       <= '0;
      step_q       <= '0;
      tile_go_q    <= 1'b0;
      frame_done_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
    end else begin
      tile_go_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) state_q <= S_SNAP;
        S_SNAP: begin
          mine_q <= mine_map;
          flag_q <= flag_map;
          step_q <= step_map;
        end
        S_REQ:  state_q <= S_WAIT;
        S_WAIT: if (drw.tile_done && last_d) begin
          state_q      <= S_FIN;
          frame_done_q <= 1'b1;
        end
`ifdef BOARD_SCANNER_DIRTY_ONLY_EN
        S_SKIP: if (last_d) begin
          state_q      <= S_FIN;
          frame_done_q <= 1'b1;
        end
`endif
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // Shared by SNAP, accepted tile_done and SKIP: load the next tile.
      if (adv_d) begin
        idx_q   <= nidx_d;
        x_q     <= nx_d;
        y_q     <= ny_d;
        color_q <= ncolor_d;
        if (nskip_d) begin
          state_q <= S_SKIP;
        end else begin
          state_q   <= S_REQ;
          tile_go_q <= 1'b1;
        end
      end
    end
  end

  assign drw.tile_go    = tile_go_q;
  assign drw.tile_x     = x_q;
  assign drw.tile_y     = y_q;
  assign drw.tile_color = color_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = frame_done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed scan scenarios with random boards, checked against a tile-list model of the board.
module tb_board_scanner;
  import gameboard_pkg::*;

`ifdef BOARD_SCANNER_DIRTY_ONLY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] mine_map, flag_map, step_map;
  logic        busy, frame_done;
  state_e      dbg_state;

  board_scanner_if drw ();

  board_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mine_map    (mine_map),
    .flag_map    (flag_map),
    .step_map    (step_map),
    .drw         (drw),
    .busy        (busy),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];           // {idx[5:0], x[7:0], y[6:0], color[2:0]}
  logic [2:0]  mdl_col [64];
  bit          mdl_valid [64];
  logic [2:0]  obs_col [64];
  logic [7:0]  last_x;
  logic [6:0]  last_y;
  int          n_go, n_fd, n_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_color(input bit m, input bit f, input bit s);
    if (s && m) return 3'b000;
    if (s)      return 3'b010;
    if (f)      return 3'b100;
    return 3'b111;
  endfunction

  task automatic build_expected(output int cnt);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [2:0] c;
      c = ref_color(mine_map[i], flag_map[i], step_map[i]);
      if (!(DIRTY && mdl_valid[i] && mdl_col[i] == c))
        exp_q.push_back({6'(i), 8'((i % 8) * 20), 7'((i / 8) * 15), c});
    end
    cnt = exp_q.size();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
  endtask

  task automatic run_scan(input int reset_tile, input bit disturb,
                          output int go_cnt, output int fd_cnt, output int exp_cnt);
    int          cyc;
    bit          done;
    logic [23:0] e;
    go_cnt = 0; fd_cnt = 0; done = 1'b0; cyc = 0;
    build_expected(exp_cnt);
    start = 1'b1; tick; start = 1'b0; tick;
    if (exp_q.size() > 0 && exp_q[0][23:18] == 6'd0)
      check("first_go_latency", drw.tile_go, 1);
    while (!done && cyc < 20000) begin
      if (drw.tile_go) begin
        go_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
        check("tile", {e[23:18], drw.tile_x, drw.tile_y, drw.tile_color}, e);
        obs_col[e[23:18]] = drw.tile_color;
        last_x = drw.tile_x;
        last_y = drw.tile_y;
        if (disturb && go_cnt == 1) begin
          mine_map = {$urandom, $urandom};
          flag_map = {$urandom, $urandom};
          step_map = {$urandom, $urandom};
        end
        if (32'(e[23:18]) == reset_tile) begin
          tick;
          reset = 1'b1; tick;
          check("abort_busy", busy, 0);
          check("abort_tile_go", drw.tile_go, 0);
          reset = 1'b0;
          for (int k = 0; k < 300; k++) begin
            tick;
            if (frame_done) fd_cnt++;
            if (drw.tile_go) go_cnt++;
          end
          clear_model();
          return;
        end
        tick;
        check("tile_go_pulse", drw.tile_go, 0);
        if (disturb && go_cnt == 5) start = 1'b1;
        tick;
        start = 1'b0;
        check("hold_stable", {drw.tile_x, drw.tile_y, drw.tile_color}, e[17:0]);
        drw.tile_done = 1'b1; tick; drw.tile_done = 1'b0;
        mdl_col[e[23:18]]   = e[2:0];
        mdl_valid[e[23:18]] = 1'b1;
        cyc += 4;
      end else begin
        if (frame_done) begin
          fd_cnt++;
          done = 1'b1;
        end
        tick;
        cyc++;
      end
    end
    check("scan_done_in_budget", done, 1);
    check("frame_done_single", frame_done, 0);
    check("idle_after_scan", busy, 0);
    check("exp_drained", exp_q.size(), 0);
    for (int k = 0; k < 30; k++) begin
      if (frame_done) fd_cnt++;
      if (drw.tile_go) go_cnt++;
      tick;
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; drw.tile_done = 1'b0;
    mine_map = '0; flag_map = '0; step_map = '0;
    for (int i = 0; i < 64; i++) obs_col[i] = 3'b101;
    clear_model();
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_tile_go", drw.tile_go, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_xyc", {drw.tile_x, drw.tile_y, drw.tile_color}, 0);
    check("rst_state", dbg_state, S_IDLE);
    start = 1'b1; tick; start = 1'b0;
    check("rst_over_start", busy, 0);
    reset = 1'b0; tick;

    // Random board, reset during WAIT of tile 30.
    mine_map = {$urandom, $urandom}; flag_map = {$urandom, $urandom}; step_map = {$urandom, $urandom};
    run_scan(30, 1'b0, n_go, n_fd, n_exp);
    check("abort_go_count", n_go, 31);
    check("abort_no_frame_done", n_fd, 0);

    // Empty board.
    mine_map = '0; flag_map = '0; step_map = '0;
    run_scan(-1, 1'b0, n_go, n_fd, n_exp);
    check("empty_go_count", n_go, 64);
    check("empty_frame_done", n_fd, 1);
    check("empty_last_x", last_x, 140);
    check("empty_last_y", last_y, 105);
    check("empty_last_color", obs_col[63], 3'b111);

    // Directed colour priorities.
    mine_map[9] = 1'b1; step_map[9] = 1'b1;
    flag_map[0] = 1'b1; step_map[0] = 1'b1;
    flag_map[1] = 1'b1;
    run_scan(-1, 1'b0, n_go, n_fd, n_exp);
    check("dir_go_count", n_go, n_exp);
    check("dir_frame_done", n_fd, 1);
    check("tile9_mine_stepped", obs_col[9], 3'b000);
    check("tile0_step_over_flag", obs_col[0], 3'b010);
    check("tile1_flag_only", obs_col[1], 3'b100);

    // Random board, maps changed and start re-pulsed mid-scan.
    mine_map = {$urandom, $urandom}; flag_map = {$urandom, $urandom}; step_map = {$urandom, $urandom};
    run_scan(-1, 1'b1, n_go, n_fd, n_exp);
    check("disturb_go_count", n_go, n_exp);
    check("disturb_frame_done", n_fd, 1);

    // Two scans differing in one step bit.
    k = $urandom_range(0, 63);
    mine_map = {$urandom, $urandom}; flag_map = {$urandom, $urandom}; step_map = {$urandom, $urandom};
    step_map[k] = 1'b0;
    run_scan(-1, 1'b0, n_go, n_fd, n_exp);
    check("pair1_go_count", n_go, n_exp);
    step_map[k] = 1'b1;
    run_scan(-1, 1'b0, n_go, n_fd, n_exp);
    check("pair2_go_count", n_go, DIRTY ? 1 : 64);
    check("pair2_frame_done", n_fd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
